elastic_pipe_reg: RTL and testbench
===================================

ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

Interface
- REQ-001: The module SHALL accept parameter WIDTH, default 32, meaning the payload bit width (1..256).
- REQ-002: The module SHALL accept parameter DEPTH, default 2, meaning the number of storage entries (1..8; need not be a power of two).
- REQ-003: The module SHALL accept parameter CW, default $clog2(DEPTH+1), meaning the occupancy counter width.
- REQ-004: CLK  input  1  sole clock; all state SHALL update on its rising edge.
- REQ-005: RST  input  1  reset, synchronous and active-high.
- REQ-006: flush  input  1  discard all stored entries.
- REQ-007: in_valid  input  1  upstream offers in_data.
- REQ-008: in_data  input  WIDTH  upstream payload.
- REQ-009: in_ready  output  1  stage can accept a payload this cycle.
- REQ-010: out_valid  output  1  out_data holds a valid payload.
- REQ-011: out_data  output  WIDTH  oldest stored payload.
- REQ-012: out_ready  input  1  downstream accepts out_data.
- REQ-013: count  output  CW  number of stored entries (0..DEPTH).

Function
- REQ-014: A push SHALL occur on a cycle with in_valid=1, in_ready=1 and flush=0.
- REQ-015: A pop SHALL occur on a cycle with out_valid=1, out_ready=1 and flush=0.
- REQ-016: in_ready SHALL be computed solely from registered state as (count < DEPTH), with no combinational path from out_ready.
- REQ-017: out_valid SHALL equal (count != 0); out_data SHALL be driven from the head entry register, with no combinational path from in_data.
- REQ-018: Entries SHALL be delivered in FIFO order, with payload bits unmodified.
- REQ-019: Latency SHALL be exactly 1 cycle: a push into an empty stage makes out_valid=1 with that payload on the next cycle.
- REQ-020: Push and pop on the same cycle SHALL leave count unchanged and advance both the read and write pointers.
- REQ-021: When full (count=DEPTH), in_ready=0; a simultaneous pop SHALL NOT enable a same-cycle push.
- REQ-022: While out_valid=1 and out_ready=0, out_data and count SHALL hold stable.
- REQ-023: The read and write pointers SHALL wrap from DEPTH-1 to 0, including for non-power-of-two DEPTH.
- REQ-024: count SHALL increment on push-only, decrement on pop-only, and never leave the range 0..DEPTH.
- REQ-025: On flush=1, the next cycle SHALL have count=0, out_valid=0, in_ready=1 and both pointers at 0.
- REQ-026: On flush=1, the concurrent in_valid payload SHALL be dropped and no pop SHALL be counted.
- REQ-027: RST SHALL take priority over flush; flush SHALL take priority over push and pop.
- REQ-028: Entry storage contents after a flush are don't-care, but out_data SHALL read 0 whenever count=0.
- REQ-029: For DEPTH=1 the block SHALL act as a half-throughput register (in_ready=0 while occupied).

Reset
- REQ-030: With RST=1 at a clock edge, the next cycle SHALL have count=0, out_valid=0, out_data=0, in_ready=1 and both pointers at 0.
- REQ-031: Reset asserted mid-stream SHALL discard all entries; in_valid and out_ready SHALL be ignored during any reset cycle.
- REQ-032: After RST deasserts, the first push SHALL be accepted on the first cycle with RST=0.

Verification (WIDTH=32, DEPTH=2 unless stated)
- REQ-033: Push 0xA, then push 0xB, with out_ready=0 -> count=2, in_ready=0, out_data=0xA held stable for 5 cycles.
- REQ-034: Continuous in_valid with out_ready=1 on sequence 1..100 -> out_data delivers 1..100 in order at one per cycle, first output 1 cycle after first push.
- REQ-035: Full stage, then flush=1 together with in_valid=1 (0xDEAD) -> next cycle count=0, out_valid=0, and 0xDEAD is never output.
- REQ-036: DEPTH=3 with 10 push/pop pairs under random out_ready stalls -> pointers wrap correctly, order is preserved, and count never exceeds 3.
- REQ-037: RST=1 asserted while count=2 -> next cycle count=0, out_data=0, in_ready=1; a push on the next cycle delivers its payload correctly.
- REQ-038: DEPTH=1 with in_valid and out_ready both held at 1 -> exactly one output every 2 cycles.

Source files
------------

// File: rtl/elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// elastic_pipe_reg
//
// Elastic pipeline stage: a small FIFO of DEPTH entries that decouples an
// upstream valid/ready producer from a downstream valid/ready consumer.
// in_ready depends only on the registered occupancy and out_data comes
// straight from the head entry, so no combinational path crosses the stage
// in either direction. Payloads come out in arrival order, one cycle after
// they are accepted into an empty stage.
//
// Parameters
//   WIDTH  payload width in bits (1..256)
//   DEPTH  number of storage entries (1..8, any value, not only powers of 2)
//   CW     occupancy counter width
//
// Ports
//   CLK        clock, all state updates on the rising edge
//   RST        synchronous active-high reset (wins over flush)
//   flush      drop every stored entry and any payload offered this cycle
//   in_valid   upstream offers in_data
//   in_data    upstream payload
//   in_ready   stage can accept a payload this cycle (count < DEPTH)
//   out_valid  out_data holds a valid payload (count != 0)
//   out_data   oldest stored payload, forced to 0 while empty
//   out_ready  downstream accepts out_data
//   count      number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module elastic_pipe_reg #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CW-1:0]    count
);

   // A single-entry stage still needs a 1-bit pointer to keep the types legal.
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Storage is sized to the full pointer range so every pointer value indexes
   // a real slot; slots at DEPTH and above are never written or read.
   localparam int SLOTS = 1 << PW;

   logic [WIDTH-1:0] mem [SLOTS];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    cnt;
   logic             push;
   logic             pop;

   // Pointer advance with explicit wrap at DEPTH-1 so non-power-of-two
   // depths cycle through exactly DEPTH slots.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   // Handshake decode: both sides look only at registered occupancy, so a
   // pop on a full cycle cannot open the input in the same cycle.
   assign in_ready  = (cnt < CW'(DEPTH));
   assign out_valid = (cnt != '0);
   assign push      = in_valid  & in_ready  & ~flush & ~RST;
   assign pop       = out_valid & out_ready & ~flush & ~RST;

   // Control stage: pointers and occupancy; reset dominates flush.
   always_ff @(posedge CLK) begin
      if (RST || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Data stage: payload storage carries no reset; an empty stage masks it.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   assign out_data = out_valid ? mem[rd_ptr] : '0;
   assign count    = cnt;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_elastic_pipe_reg
//
// Three instances: A (WIDTH=32, DEPTH=2), B (DEPTH=3), C (DEPTH=1).
// A and B are shadowed by queue models that apply the handshake rules at each
// rising edge; outputs are sampled on the falling edge, inputs driven there.
// -----------------------------------------------------------------------------
module tb_elastic_pipe_reg;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Instance A: DEPTH=2
   logic        a_rst, a_flush, a_iv, a_ir, a_ov, a_or;
   logic [31:0] a_id, a_od;
   logic [1:0]  a_cnt;
   // Instance B: DEPTH=3
   logic        b_rst, b_flush, b_iv, b_ir, b_ov, b_or;
   logic [31:0] b_id, b_od;
   logic [1:0]  b_cnt;
   // Instance C: DEPTH=1
   logic        c_rst, c_flush, c_iv, c_ir, c_ov, c_or;
   logic [31:0] c_id, c_od;
   logic [0:0]  c_cnt;

   elastic_pipe_reg #(.WIDTH(32), .DEPTH(2)) dut_a (
      .CLK(CLK), .RST(a_rst), .flush(a_flush), .in_valid(a_iv), .in_data(a_id),
      .in_ready(a_ir), .out_valid(a_ov), .out_data(a_od), .out_ready(a_or),
      .count(a_cnt));

   elastic_pipe_reg #(.WIDTH(32), .DEPTH(3)) dut_b (
      .CLK(CLK), .RST(b_rst), .flush(b_flush), .in_valid(b_iv), .in_data(b_id),
      .in_ready(b_ir), .out_valid(b_ov), .out_data(b_od), .out_ready(b_or),
      .count(b_cnt));

   elastic_pipe_reg #(.WIDTH(32), .DEPTH(1)) dut_c (
      .CLK(CLK), .RST(c_rst), .flush(c_flush), .in_valid(c_iv), .in_data(c_id),
      .in_ready(c_ir), .out_valid(c_ov), .out_data(c_od), .out_ready(c_or),
      .count(c_cnt));

   // Reference models: a queue of stored payloads per instance.
   logic [31:0] qa[$];
   logic [31:0] qb[$];

   always @(posedge CLK) begin
      if (a_rst || a_flush) begin
         qa.delete();
      end else if (a_iv && qa.size() < 2) begin
         if (a_or && qa.size() > 0) void'(qa.pop_front());
         qa.push_back(a_id);
      end else if (a_or && qa.size() > 0) begin
         void'(qa.pop_front());
      end
   end

   always @(posedge CLK) begin
      if (b_rst || b_flush) begin
         qb.delete();
      end else if (b_iv && qb.size() < 3) begin
         if (b_or && qb.size() > 0) void'(qb.pop_front());
         qb.push_back(b_id);
      end else if (b_or && qb.size() > 0) begin
         void'(qb.pop_front());
      end
   end

   // Expected {out_valid, in_ready, count, out_data} from the model queues.
   function automatic logic [35:0] exp_a();
      int n;
      n = qa.size();
      return {(n != 0), (n < 2), 2'(n), ((n != 0) ? qa[0] : 32'h0)};
   endfunction

   function automatic logic [35:0] exp_b();
      int n;
      n = qb.size();
      return {(n != 0), (n < 3), 2'(n), ((n != 0) ? qb[0] : 32'h0)};
   endfunction

   // Empty instance A with a one-cycle flush; returns on a falling edge.
   task automatic clear_a();
      a_flush = 1'b1; a_iv = 1'b0; a_or = 1'b0;
      @(negedge CLK);
      a_flush = 1'b0;
   endtask

   task automatic test_reset();
      a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
      a_iv = 1'b1; a_or = 1'b1; a_id = 32'hCAFE_0001;
      repeat (3) @(negedge CLK);
      checks++;
      if ({a_cnt, a_ov, a_ir, a_od} !== {2'd0, 1'b0, 1'b1, 32'h0}) begin
         errors++;
         $display("FAIL reset_a got %h want %h", {a_cnt, a_ov, a_ir, a_od}, {2'd0, 1'b0, 1'b1, 32'h0});
      end
      checks++;
      if ({b_cnt, b_ov, b_ir, b_od} !== {2'd0, 1'b0, 1'b1, 32'h0}) begin
         errors++;
         $display("FAIL reset_b got %h want %h", {b_cnt, b_ov, b_ir, b_od}, {2'd0, 1'b0, 1'b1, 32'h0});
      end
      checks++;
      if ({c_cnt, c_ov, c_ir, c_od} !== {1'd0, 1'b0, 1'b1, 32'h0}) begin
         errors++;
         $display("FAIL reset_c got %h want %h", {c_cnt, c_ov, c_ir, c_od}, {1'd0, 1'b0, 1'b1, 32'h0});
      end
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
      a_iv = 1'b0; a_or = 1'b0;
   endtask

   task automatic test_fill_hold();
      clear_a();
      a_iv = 1'b1; a_or = 1'b0; a_id = 32'hA;
      @(negedge CLK);
      a_id = 32'hB;
      @(negedge CLK);
      a_iv = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({a_cnt, a_ir, a_ov, a_od} !== {2'd2, 1'b0, 1'b1, 32'hA}) begin
            errors++;
            $display("FAIL hold cyc %0d got %h want %h", i, {a_cnt, a_ir, a_ov, a_od}, {2'd2, 1'b0, 1'b1, 32'hA});
         end
         @(negedge CLK);
      end
      a_or = 1'b1;
      @(negedge CLK);
      checks++;
      if ({a_cnt, a_ov, a_od} !== {2'd1, 1'b1, 32'hB}) begin
         errors++;
         $display("FAIL drain_b got %h want %h", {a_cnt, a_ov, a_od}, {2'd1, 1'b1, 32'hB});
      end
      @(negedge CLK);
      checks++;
      if ({a_cnt, a_ov, a_ir, a_od} !== {2'd0, 1'b0, 1'b1, 32'h0}) begin
         errors++;
         $display("FAIL drain_empty got %h want %h", {a_cnt, a_ov, a_ir, a_od}, {2'd0, 1'b0, 1'b1, 32'h0});
      end
      a_or = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [33:0] exp;
      clear_a();
      for (int cyc = 0; cyc <= 101; cyc++) begin
         if (cyc >= 1 && cyc <= 100) exp = {1'b1, 1'b1, 32'(cyc)};
         else exp = {1'b0, 1'b1, 32'h0};
         checks++;
         if ({a_ov, a_ir, a_od} !== exp) begin
            errors++;
            $display("FAIL stream cyc %0d got %h want %h", cyc, {a_ov, a_ir, a_od}, exp);
         end
         a_iv = (cyc < 100);
         a_id = 32'(cyc + 1);
         a_or = 1'b1;
         @(negedge CLK);
      end
      a_iv = 1'b0; a_or = 1'b0;
   endtask

   task automatic test_flush();
      clear_a();
      a_iv = 1'b1; a_or = 1'b0; a_id = $urandom;
      @(negedge CLK);
      a_id = $urandom;
      @(negedge CLK);
      checks++;
      if ({a_cnt, a_ir} !== {2'd2, 1'b0}) begin
         errors++;
         $display("FAIL flush_full got %h want %h", {a_cnt, a_ir}, {2'd2, 1'b0});
      end
      a_flush = 1'b1; a_iv = 1'b1; a_id = 32'hDEAD; a_or = 1'b1;
      @(negedge CLK);
      checks++;
      if ({a_cnt, a_ov, a_ir, a_od} !== {2'd0, 1'b0, 1'b1, 32'h0}) begin
         errors++;
         $display("FAIL flush_full_next got %h want %h", {a_cnt, a_ov, a_ir, a_od}, {2'd0, 1'b0, 1'b1, 32'h0});
      end
      a_flush = 1'b0; a_iv = 1'b0; a_or = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({a_ov, a_od} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL flush_quiet cyc %0d got %h want %h", i, {a_ov, a_od}, {1'b0, 32'h0});
         end
         @(negedge CLK);
      end
      // Flush while the input is open: the offered payload must still drop.
      a_iv = 1'b1; a_or = 1'b0; a_id = 32'h1111;
      @(negedge CLK);
      a_flush = 1'b1; a_id = 32'hDEAD;
      @(negedge CLK);
      checks++;
      if ({a_cnt, a_ov, a_ir, a_od} !== {2'd0, 1'b0, 1'b1, 32'h0}) begin
         errors++;
         $display("FAIL flush_open got %h want %h", {a_cnt, a_ov, a_ir, a_od}, {2'd0, 1'b0, 1'b1, 32'h0});
      end
      a_flush = 1'b0; a_id = 32'h55;
      @(negedge CLK);
      a_iv = 1'b0;
      checks++;
      if ({a_cnt, a_ov, a_od} !== {2'd1, 1'b1, 32'h55}) begin
         errors++;
         $display("FAIL flush_refill got %h want %h", {a_cnt, a_ov, a_od}, {2'd1, 1'b1, 32'h55});
      end
      a_or = 1'b1;
      @(negedge CLK);
      a_or = 1'b0;
   endtask

   task automatic test_reset_mid();
      clear_a();
      a_iv = 1'b1; a_or = 1'b0; a_id = $urandom;
      @(negedge CLK);
      a_id = $urandom;
      @(negedge CLK);
      a_rst = 1'b1; a_iv = 1'b1; a_id = 32'hBAD0_BAD0; a_or = 1'b1;
      @(negedge CLK);
      checks++;
      if ({a_cnt, a_ov, a_ir, a_od} !== {2'd0, 1'b0, 1'b1, 32'h0}) begin
         errors++;
         $display("FAIL rst_mid got %h want %h", {a_cnt, a_ov, a_ir, a_od}, {2'd0, 1'b0, 1'b1, 32'h0});
      end
      a_rst = 1'b0; a_iv = 1'b1; a_id = 32'h1234; a_or = 1'b0;
      @(negedge CLK);
      a_iv = 1'b0;
      checks++;
      if ({a_cnt, a_ov, a_ir, a_od} !== {2'd1, 1'b1, 1'b1, 32'h1234}) begin
         errors++;
         $display("FAIL rst_first_push got %h want %h", {a_cnt, a_ov, a_ir, a_od}, {2'd1, 1'b1, 1'b1, 32'h1234});
      end
      a_or = 1'b1;
      @(negedge CLK);
      a_or = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         checks++;
         if ({a_ov, a_ir, a_cnt, a_od} !== exp_a()) begin
            errors++;
            $display("FAIL rand_a cyc %0d got %h want %h", i, {a_ov, a_ir, a_cnt, a_od}, exp_a());
         end
         a_rst   = ($urandom_range(0, 59) == 0);
         a_flush = ($urandom_range(0, 24) == 0);
         a_iv    = ($urandom_range(0, 3) != 0);
         a_or    = ($urandom_range(0, 2) != 0);
         a_id    = $urandom;
         @(negedge CLK);
      end
      a_rst = 1'b0; a_flush = 1'b0; a_iv = 1'b0; a_or = 1'b0;
   endtask

   task automatic test_wrap_d3();
      logic [31:0] sent[$];
      int nsent;
      int nrec;
      int cyc;
      nsent = 0; nrec = 0; cyc = 0;
      while (nrec < 10 && cyc < 400) begin
         checks++;
         if ({b_ov, b_ir, b_cnt, b_od} !== exp_b()) begin
            errors++;
            $display("FAIL wrap_model cyc %0d got %h want %h", cyc, {b_ov, b_ir, b_cnt, b_od}, exp_b());
         end
         b_iv = (nsent < 10) && ($urandom_range(0, 2) != 0);
         b_or = ($urandom_range(0, 2) == 0);
         b_id = $urandom;
         if (b_iv && b_ir) begin
            sent.push_back(b_id);
            nsent++;
         end
         if (b_ov && b_or) begin
            checks++;
            if (sent.size() == 0 || b_od !== sent[0]) begin
               errors++;
               $display("FAIL wrap_order item %0d got %h want %h", nrec, b_od, (sent.size() != 0) ? sent[0] : 32'h0);
            end
            if (sent.size() != 0) void'(sent.pop_front());
            nrec++;
         end
         @(negedge CLK);
         cyc++;
      end
      checks++;
      if (nrec != 10) begin
         errors++;
         $display("FAIL wrap_budget got %0d items want 10", nrec);
      end
      b_iv = 1'b0; b_or = 1'b0;
   endtask

   task automatic test_depth1();
      logic [31:0] base;
      logic [34:0] exp;
      base = $urandom;
      for (int cyc = 0; cyc < 20; cyc++) begin
         exp = {cyc[0], ~cyc[0], cyc[0], (cyc[0] ? base + 32'(cyc / 2) : 32'h0)};
         checks++;
         if ({c_ov, c_ir, c_cnt, c_od} !== exp) begin
            errors++;
            $display("FAIL depth1 cyc %0d got %h want %h", cyc, {c_ov, c_ir, c_cnt, c_od}, exp);
         end
         c_iv = 1'b1; c_or = 1'b1;
         c_id = base + 32'(cyc / 2);
         @(negedge CLK);
      end
      c_iv = 1'b0; c_or = 1'b0;
   endtask

   initial begin
      a_rst = 1'b1; a_flush = 1'b0; a_iv = 1'b0; a_or = 1'b0; a_id = '0;
      b_rst = 1'b1; b_flush = 1'b0; b_iv = 1'b0; b_or = 1'b0; b_id = '0;
      c_rst = 1'b1; c_flush = 1'b0; c_iv = 1'b0; c_or = 1'b0; c_id = '0;
      test_reset();
      test_fill_hold();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_random();
      test_wrap_d3();
      test_depth1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
